// File: rtl/mem_stage_if.sv
// EX->MEM input bus, SRAM read data and MEM->WB / forwarding outputs of the memory stage.
// The master side drives the stage inputs; the slave side is the stage itself.
interface mem_stage_if #(
    parameter int EX_TO_MEM_WD = 147,
    parameter int MEM_TO_WB_WD = 136
);
    logic [5:0]              stall;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [31:0]             data_sram_rdata;
    logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
    logic [MEM_TO_WB_WD-1:0] mem_to_id_forwarding;

    modport master (
        output stall, ex_to_mem_bus, data_sram_rdata,
        input  mem_to_wb_bus, mem_to_id_forwarding
    );

    modport slave (
        input  stall, ex_to_mem_bus, data_sram_rdata,
        output mem_to_wb_bus, mem_to_id_forwarding
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the EX->MEM bus, aligns/extends SRAM load data
// and holds it across stalls, driving the MEM->WB bus and an identical forwarding copy.
module mem_stage (
    input  logic         clk,
    input  logic         rst,
    mem_stage_if.slave   bus
);
    typedef struct packed {
        logic [4:0]  op_mem;
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi_result;
        logic [31:0] lo_result;
        logic [31:0] pc;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_bus_t;

    // FRESH: first cycle of a new occupant, SRAM data is live; HELD: data comes from rdata_r.
    typedef enum logic {HELD = 1'b0, FRESH = 1'b1} occ_state_e;

    ex_bus_t    bus_r;
    occ_state_e state;
    logic [31:0] rdata_r;

    logic stop_mem;
    logic stop_wb;
    assign stop_mem = bus.stall[3];
    assign stop_wb  = bus.stall[4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_r   <= '0;
            state   <= HELD;
            rdata_r <= '0;
        end else begin
            // NOTE: non-blocking so rdata_r samples with the state of this cycle, not the next.
            if (state == FRESH) rdata_r <= bus.data_sram_rdata;
            if (!stop_mem) begin
                bus_r <= bus.ex_to_mem_bus;
                state <= FRESH;
            end else if (!stop_wb) begin
                bus_r <= '0;
                state <= HELD;
            end else begin
                state <= HELD;
            end
        end
    end

    logic [1:0]   addr_lo;
    logic [31:0]  word;
    logic [7:0]   lane_byte;
    logic [15:0]  lane_half;
    logic [31:0]  load_res;
    logic [31:0]  rf_wdata;
    logic [135:0] wb_bus;

    always_comb begin
        // NOTE: every output of this block is assigned first so no latch is inferred.
        addr_lo   = bus_r.ex_result[1:0];
        word      = (state == FRESH) ? bus.data_sram_rdata : rdata_r;
        lane_byte = word[{addr_lo, 3'b000} +: 8];
        lane_half = addr_lo[1] ? word[31:16] : word[15:0];
        load_res  = word;
        if (bus_r.op_mem[1])      load_res = {{24{lane_byte[7]}}, lane_byte};
        else if (bus_r.op_mem[2]) load_res = {24'd0, lane_byte};
        else if (bus_r.op_mem[3]) load_res = {{16{lane_half[15]}}, lane_half};
        else if (bus_r.op_mem[4]) load_res = {16'd0, lane_half};
        rf_wdata = (bus_r.op_mem != 5'd0) ? load_res : bus_r.ex_result;
    end

    assign wb_bus = {bus_r.hi_we, bus_r.lo_we, bus_r.hi_result, bus_r.lo_result,
                     bus_r.pc, bus_r.rf_we, bus_r.rf_waddr, rf_wdata};

    assign bus.mem_to_wb_bus        = wb_bus;
    assign bus.mem_to_id_forwarding = wb_bus;

    // Store-side controls and foreign stall bits are consumed by other stages.
    logic unused_bits;
    assign unused_bits = ^{bus.stall[5], bus.stall[2:0], bus_r.data_ram_en,
                           bus_r.data_ram_wen, bus_r.sel_rf_res};
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboarded bench for mem_stage: a driver pushes expected outputs from a
// behavioural occupancy model; a negedge monitor pops and compares.
module tb_mem_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_stage_if bus_if ();
    mem_stage dut (.clk(clk), .rst(rst), .bus(bus_if));

    typedef struct packed {
        logic [4:0]  op_mem;
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi_result;
        logic [31:0] lo_result;
        logic [31:0] pc;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_bus_t;

    localparam logic [4:0] OP_LW = 5'b00001, OP_LB = 5'b00010, OP_LBU = 5'b00100,
                           OP_LH = 5'b01000, OP_LHU = 5'b10000, OP_ALU = 5'b00000;
    localparam logic [5:0] GO = 6'b000000, HOLD = 6'b011111, BUBBLE = 6'b001111;

    // Model: what occupies the stage, how many cycles it has been there (-1 = none),
    // and the SRAM word seen during its first cycle.
    ex_bus_t     occ;
    int          occ_age;
    logic [31:0] first_word;

    logic [135:0] exp_q[$];
    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] load_value(input logic [4:0] op, input logic [31:0] addr,
                                               input logic [31:0] w, input logic [31:0] alu);
        logic [31:0] b, h;
        b = (w >> (8 * addr[1:0])) & 32'hFF;
        h = addr[1] ? (w >> 16) : (w & 32'hFFFF);
        case (op)
            OP_LW:   return w;
            OP_LB:   return (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
            OP_LBU:  return b;
            OP_LH:   return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
            OP_LHU:  return h;
            default: return alu;
        endcase
    endfunction

    function automatic logic [135:0] expect_out(input logic [31:0] live_rdata);
        logic [31:0] w;
        w = (occ_age == 0) ? live_rdata : first_word;
        return {occ.hi_we, occ.lo_we, occ.hi_result, occ.lo_result, occ.pc, occ.rf_we,
                occ.rf_waddr, load_value(occ.op_mem, occ.ex_result, w, occ.ex_result)};
    endfunction

    function automatic ex_bus_t rand_bus(input logic [4:0] op, input logic [31:0] res);
        ex_bus_t b;
        b.op_mem       = op;
        b.hi_we        = 1'($urandom);
        b.lo_we        = 1'($urandom);
        b.hi_result    = $urandom;
        b.lo_result    = $urandom;
        b.pc           = $urandom;
        b.data_ram_en  = 1'($urandom);
        b.data_ram_wen = 4'($urandom);
        b.sel_rf_res   = 1'($urandom);
        b.rf_we        = 1'($urandom);
        b.rf_waddr     = 5'($urandom);
        b.ex_result    = res;
        return b;
    endfunction

    // Called just after a posedge: drive this cycle's SRAM data and next-edge controls.
    task automatic cycle(input logic [5:0] st, input ex_bus_t b, input logic [31:0] rd,
                         input logic r);
        rst = r;
        bus_if.stall           = st;
        bus_if.ex_to_mem_bus   = b;
        bus_if.data_sram_rdata = rd;
        if (r) begin
            occ = '0; occ_age = -1; first_word = '0;
        end
        exp_q.push_back(expect_out(rd));
        @(posedge clk); #1;
        cyc++;
        if (!r) begin
            if (occ_age == 0) first_word = rd;
            if (!st[3]) begin
                occ = b; occ_age = 0;
            end else if (!st[4]) begin
                occ = '0; occ_age = -1;
            end else if (occ_age >= 0) begin
                occ_age++;
            end
        end
    endtask

    initial begin : monitor
        logic [135:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wb_bus", bus_if.mem_to_wb_bus, e);
                check("fwd_bus", bus_if.mem_to_id_forwarding, e);
            end
        end
    end

    initial begin : driver
        ex_bus_t lw, alu, hi_alu;
        logic [4:0] ops [6] = '{OP_ALU, OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU};
        rst = 1'b1;
        bus_if.stall = '0;
        bus_if.ex_to_mem_bus = '0;
        bus_if.data_sram_rdata = '0;
        occ = '0; occ_age = -1; first_word = '0;
        @(posedge clk); #1;

        cycle(GO, '0, $urandom, 1'b1);
        cycle(GO, '0, $urandom, 1'b1);

        // Loads of every width at the addresses and data patterns of interest.
        lw = rand_bus(OP_LW, 32'h100); lw.rf_we = 1'b1; lw.rf_waddr = 5'd7;
        cycle(GO, lw, $urandom, 1'b0);
        cycle(GO, rand_bus(OP_LB, 32'h103), 32'h8899AABB, 1'b0);
        cycle(GO, rand_bus(OP_LBU, 32'h103), 32'h80FF0011, 1'b0);
        cycle(GO, rand_bus(OP_LH, 32'h102), 32'h80FF0011, 1'b0);
        cycle(GO, rand_bus(OP_LHU, 32'h102), 32'h9ABC1234, 1'b0);
        hi_alu = rand_bus(OP_ALU, 32'h12345678); hi_alu.hi_we = 1'b1; hi_alu.hi_result = 32'hDEAD0000;
        cycle(GO, hi_alu, 32'h9ABC1234, 1'b0);
        cycle(GO, rand_bus(OP_LW, 32'h200), 32'hCAFEF00D, 1'b0);

        // Load held for three stalled edges while SRAM data changes.
        cycle(HOLD, rand_bus(OP_ALU, $urandom), 32'h13572468, 1'b0);
        cycle(HOLD, rand_bus(OP_ALU, $urandom), 32'hFFFFFFFF, 1'b0);
        cycle(HOLD, rand_bus(OP_ALU, $urandom), 32'hFFFFFFFF, 1'b0);
        cycle(GO, rand_bus(OP_LB, 32'h301), 32'hFFFFFFFF, 1'b0);

        // Bubble, then a held bubble, then a held ALU op.
        cycle(BUBBLE, rand_bus(OP_LW, $urandom), 32'h00C0FFEE, 1'b0);
        cycle(HOLD, rand_bus(OP_LW, $urandom), 32'h11111111, 1'b0);
        alu = rand_bus(OP_ALU, 32'h0BADBEEF);
        cycle(GO, alu, 32'h22222222, 1'b0);
        cycle(HOLD, rand_bus(OP_LW, $urandom), 32'h33333333, 1'b0);
        cycle(GO, rand_bus(OP_LH, 32'h401), 32'h44444444, 1'b0);

        // Reset asserted asynchronously while a load is held.
        cycle(HOLD, rand_bus(OP_ALU, $urandom), 32'h11112222, 1'b0);
        cycle(HOLD, rand_bus(OP_ALU, $urandom), 32'h33334444, 1'b0);
        cycle(HOLD, rand_bus(OP_LW, $urandom), 32'h55556666, 1'b1);
        cycle(GO, rand_bus(OP_LW, $urandom), 32'h77778888, 1'b1);
        cycle(GO, rand_bus(OP_LHU, 32'h502), 32'h9999AAAA, 1'b0);
        cycle(GO, rand_bus(OP_ALU, $urandom), 32'hA5A5C3C3, 1'b0);

        // Randomized traffic with random stalls and occasional reset.
        for (int i = 0; i < 400; i++) begin
            logic [5:0] st;
            st = 6'($urandom);
            cycle(st, rand_bus(ops[$urandom_range(5)], $urandom), $urandom,
                  ($urandom_range(63) == 0));
        end
        cycle(GO, '0, $urandom, 1'b0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage sitting directly downstream of the execute stage. Registers the EX→MEM bus under stall/bubble control, aligns and sign/zero-extends synchronous data-SRAM read data for lw/lb/lbu/lh/lhu, and emits the MEM→WB bus plus an identical forwarding copy to ID. A read-data hold register keeps load results valid while the stage is stalled.

## Interface
- EX_TO_MEM_WD, 147, width of incoming bus
- MEM_TO_WB_WD, 136, width of outgoing bus
- clk  in  1  clock, all state on posedge
- rst  in  1  reset; asynchronous, active-high
- stall  in  StallBus (6)  global stall vector; bit 3 = this stage, bit 4 = WB; Stop = 1
- ex_to_mem_bus  in  147  {op_mem[4:0] 146:142, hi_we 141, lo_we 140, hi_result 139:108, lo_result 107:76, pc 75:44, data_ram_en 43, data_ram_wen 42:39, sel_rf_res 38, rf_we 37, rf_waddr 36:32, ex_result 31:0}
- data_sram_rdata  in  32  SRAM read data, valid the cycle after the address was presented
- mem_to_wb_bus  out  136  {hi_we 135, lo_we 134, hi 133:102, lo 101:70, pc 69:38, rf_we 37, rf_waddr 36:32, rf_wdata 31:0}
- mem_to_id_forwarding  out  136  bit-identical copy of mem_to_wb_bus

## Operation
- Bus register bus_r (147b): stall[3]=Stop & stall[4]=NoStop → load zero (bubble); stall[3]=NoStop → load ex_to_mem_bus; otherwise hold.
- op_mem one-hot: [0] lw, [1] lb, [2] lbu, [3] lh, [4] lhu. Zero = non-load.
- Address = bus_r.ex_result; a = addr[1:0]. Little-endian byte lanes.
- Raw word w = fresh ? data_sram_rdata : rdata_r.
- Load result: lw → w; lb/lbu → byte w[8a+7:8a], sign/zero-extended; lh/lhu → half w[31:16] if a[1] else w[15:0], sign/zero-extended; a[0] ignored for halves, a ignored for lw (no alignment exception).
- rf_wdata = (op_mem≠0) ? load result : ex_result. sel_rf_res, data_ram_en, data_ram_wen not forwarded.
- hi_we, lo_we, hi_result, lo_result, pc, rf_we, rf_waddr pass through unchanged.
- Read-data hold: flag fresh=1 in the first cycle after bus_r is loaded with a new (non-bubble) value, else 0. When fresh=1, rdata_r ← data_sram_rdata on the clock edge. While stalled, w comes from rdata_r so the result stays stable.
- Two-state view: FRESH (first cycle of occupancy, SRAM data live) → HELD (every subsequent stalled cycle); any new load of bus_r → FRESH; bubble → HELD with zero bus.

## Timing
- Reset (async, immediate): bus_r=0, rdata_r=0, fresh=0; both outputs all-zero (rf_we=0, hi_we=lo_we=0).
- Latency: bus captured at edge N; outputs valid combinationally during cycle N; WB captures at edge N+1 unless stalled.
- Outputs are combinational from bus_r, fresh, rdata_r, data_sram_rdata only; no path from ex_to_mem_bus to outputs.
- Stall held k cycles on a load: rf_wdata identical in all k+1 cycles even if data_sram_rdata changes after the first.
- Bubble and stall same cycle: bubble rule wins only when stall[4]=NoStop; stall[3]=stall[4]=Stop → hold.
- Reset asserted mid-stall: outputs zero immediately; first post-reset load behaves as FRESH.
- Back-to-back loads with no stall: each cycle is FRESH, rdata_r rewritten every cycle.

## Test plan
- lw: bus_r op_mem=00001, addr 0x100, rdata 0x8899AABB → rf_wdata 0x8899AABB, rf_we/waddr passed.
- lb/lbu at addr 0x103, rdata 0x80FF0011 → lb 0xFFFFFF80, lbu 0x00000080; lh/lhu at 0x102, rdata 0x9ABC1234 → 0xFFFF9ABC / 0x00009ABC.
- Non-load ALU op, ex_result 0x12345678, hi_we=1 hi_result 0xDEAD0000 → rf_wdata 0x12345678, hi passes through, rdata ignored.
- lw then stall[3]=stall[4]=1 for 3 cycles with rdata changing to 0xFFFFFFFF after first cycle → rf_wdata stays first value all 4 cycles.
- stall=6'b001111 (EX/MEM stopped, WB free) → next cycle outputs all zero; stall=6'b011111 → bus held.
- Assert rst asynchronously mid-cycle during held load → outputs zero before next clk edge; release, lw enters → correct FRESH result.
